// File: rtl/sl_pkg.sv
// Shared definitions for the SL transmitter scheduler: register bit map,
// config reset value, legal word-length/frequency limits and FSM states.
package sl_pkg;

  localparam int SR_BIT   = 0;
  localparam int BQL      = 1;
  localparam int BQH      = 6;
  localparam int IRQM_BIT = 7;
  localparam int FQL      = 8;
  localparam int FQH      = 10;
  localparam int SIP_BIT  = 16;

  localparam logic [15:0] CFG_RESET = 16'h0210;

  localparam int BQ_MIN = 8;
  localparam int BQ_MAX = 32;
  localparam int FQ_MAX = 4;

  typedef enum logic [3:0] {
    S_IDLE,
    S_CHECK,
    S_WR_CFG,
    S_GAP,
    S_WR_DATA,
    S_WAIT_START,
    S_WAIT_DONE,
    S_DONE,
    S_ERR
  } state_e;

  // IRQM and SR are always written as zero by the scheduler.
  function automatic logic [15:0] make_cfg(input logic [5:0] bq, input logic [2:0] fq);
    return {5'b0, fq, 1'b0, bq, 1'b0};
  endfunction

  function automatic logic cfg_valid(input logic [5:0] bq, input logic [2:0] fq);
    return !bq[0] && (bq >= 6'(BQ_MIN)) && (bq <= 6'(BQ_MAX)) && (fq <= 3'(FQ_MAX));
  endfunction

endpackage

// File: rtl/sl_rr_arbiter.sv
// Combinational round-robin pick: first set request at or after ptr_i,
// wrapping at N_REQ. The pointer register lives in the scheduler.
module sl_rr_arbiter #(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [ID_W-1:0]  ptr_i,
  output logic             gnt_vld_o,
  output logic [ID_W-1:0]  gnt_idx_o
);

  logic [ID_W-1:0] idx;

  // Walk from farthest to nearest so the candidate closest to ptr_i wins.
  always_comb begin
    gnt_vld_o = 1'b0;
    gnt_idx_o = '0;
    idx       = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      idx = ID_W'((int'(ptr_i) + k) % N_REQ);
      if (req_i[idx]) begin
        gnt_vld_o = 1'b1;
        gnt_idx_o = idx;
      end
    end
  end

endmodule

// File: rtl/sl_tx_scheduler.sv
// Round-robin sharing of one SL transmitter: validate config, rewrite the
// config register only on change, write the data word, then track SIP.
module sl_tx_scheduler
  import sl_pkg::*;
#(
  parameter int N_REQ         = 4,
  parameter int ID_W          = $clog2(N_REQ),
  parameter int START_TIMEOUT = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_REQ-1:0]   req,
  input  logic [N_REQ*32-1:0] req_data,
  input  logic [N_REQ*6-1:0] req_bq,
  input  logic [N_REQ*3-1:0] req_fq,
  output logic [N_REQ-1:0]   ack,
  output logic [N_REQ-1:0]   err,
  output logic               busy,
  output logic [ID_W-1:0]    grant_id,
  output logic [31:0]        tx_d_in,
  output logic               tx_addr,
  output logic               tx_wr_en,
  input  logic [31:0]        tx_d_out
);

  localparam int CNT_W = $clog2(START_TIMEOUT + 1);

  state_e           state_q;
  logic [ID_W-1:0]  grant_q, ptr_q, ptr_d;
  logic [31:0]      data_q;
  logic [15:0]      cfg_q, cfg_d, shadow_q;
  logic             cfg_ok_q, cfg_ok_d;
  logic [CNT_W-1:0] cnt_q;
  logic [N_REQ-1:0] ack_q, err_q;
  logic             tx_wr_en_q, tx_addr_q;
  logic [31:0]      tx_d_in_q;

  logic             arb_vld;
  logic [ID_W-1:0]  arb_idx;
  logic [31:0]      sel_data;
  logic [5:0]       sel_bq;
  logic [2:0]       sel_fq;
  logic             sip;
  logic             unused_dout;

  assign sip         = tx_d_out[SIP_BIT];
  assign unused_dout = ^{tx_d_out[31:SIP_BIT+1], tx_d_out[SIP_BIT-1:0]};

  sl_rr_arbiter #(.N_REQ(N_REQ), .ID_W(ID_W)) u_arb (
    .req_i     (req),
    .ptr_i     (ptr_q),
    .gnt_vld_o (arb_vld),
    .gnt_idx_o (arb_idx)
  );

  always_comb begin
    sel_data = '0;
    sel_bq   = '0;
    sel_fq   = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (arb_idx == ID_W'(i)) begin
        sel_data = req_data[i*32 +: 32];
        sel_bq   = req_bq[i*6 +: 6];
        sel_fq   = req_fq[i*3 +: 3];
      end
    end
  end

  assign cfg_d    = make_cfg(sel_bq, sel_fq);
  assign cfg_ok_d = cfg_valid(sel_bq, sel_fq);
  assign ptr_d    = (grant_q == ID_W'(N_REQ - 1)) ? '0 : grant_q + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      grant_q    <= '0;
      ptr_q      <= '0;
      data_q     <= '0;
      cfg_q      <= CFG_RESET;
      cfg_ok_q   <= 1'b0;
      shadow_q   <= CFG_RESET;
      cnt_q      <= '0;
      ack_q      <= '0;
      err_q      <= '0;
      tx_wr_en_q <= 1'b0;
      tx_addr_q  <= 1'b1;
      tx_d_in_q  <= '0;
    end else begin
      ack_q      <= '0;
      err_q      <= '0;
      tx_wr_en_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (arb_vld && !sip) begin
            grant_q  <= arb_idx;
            data_q   <= sel_data;
            cfg_q    <= cfg_d;
            cfg_ok_q <= cfg_ok_d;
            state_q  <= S_CHECK;
          end
        end
        S_CHECK: begin
          if (!cfg_ok_q) begin
            err_q[grant_q] <= 1'b1;
            state_q        <= S_ERR;
          end else if (cfg_q == shadow_q) begin
            tx_wr_en_q <= 1'b1;
            tx_addr_q  <= 1'b0;
            tx_d_in_q  <= data_q;
            state_q    <= S_WR_DATA;
          end else begin
            tx_wr_en_q <= 1'b1;
            tx_addr_q  <= 1'b1;
            tx_d_in_q  <= {16'h0, cfg_q};
            shadow_q   <= cfg_q;
            state_q    <= S_WR_CFG;
          end
        end
        // Strobe drops for one cycle so the transmitter latches the new config.
        S_WR_CFG: state_q <= S_GAP;
        S_GAP: begin
          tx_wr_en_q <= 1'b1;
          tx_addr_q  <= 1'b0;
          tx_d_in_q  <= data_q;
          state_q    <= S_WR_DATA;
        end
        S_WR_DATA: begin
          tx_addr_q <= 1'b1;
          cnt_q     <= '0;
          state_q   <= S_WAIT_START;
        end
        S_WAIT_START: begin
          if (sip) begin
            state_q <= S_WAIT_DONE;
          end else if (cnt_q == CNT_W'(START_TIMEOUT - 1)) begin
            err_q[grant_q] <= 1'b1;
            state_q        <= S_ERR;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_WAIT_DONE: begin
          if (!sip) begin
            ack_q[grant_q] <= 1'b1;
            state_q        <= S_DONE;
          end
        end
        S_DONE, S_ERR: begin
          ptr_q   <= ptr_d;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign ack      = ack_q;
  assign err      = err_q;
  assign busy     = (state_q != S_IDLE);
  assign grant_id = grant_q;
  assign tx_d_in  = tx_d_in_q;
  assign tx_addr  = tx_addr_q;
  assign tx_wr_en = tx_wr_en_q;

endmodule

// File: tb/tb_sl_tx_scheduler.sv
// Directed bench for sl_tx_scheduler with a small transmitter model;
// expected writes/responses are queued and checked by a separate monitor.
module tb_sl_tx_scheduler;

  localparam int N = 4;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [N-1:0]    req = '0;
  logic [N*32-1:0] req_data = '0;
  logic [N*6-1:0]  req_bq = '0;
  logic [N*3-1:0]  req_fq = '0;
  logic [N-1:0]    ack, err;
  logic            busy;
  logic [1:0]      grant_id;
  logic [31:0]     tx_d_in, tx_d_out;
  logic            tx_addr, tx_wr_en;

  int checks = 0;
  int failures = 0;

  logic [32:0] exp_wr[$];
  logic [7:0]  exp_resp[$];
  logic [32:0] ew;
  logic [7:0]  er;

  // Transmitter model: SIP rises 4 cycles after a data write, stays 6 cycles.
  logic [15:0] cfg_m = 16'h0210;
  logic [3:0]  start_cnt = '0;
  logic [3:0]  sip_cnt = '0;
  logic        tx_hold = 1'b0;
  logic        sip_force = 1'b0;
  logic        sip_m;

  assign sip_m    = (sip_cnt != 0) || sip_force;
  assign tx_d_out = {15'h0, sip_m, cfg_m};

  always @(posedge clk) begin
    if (tx_wr_en && tx_addr) cfg_m <= tx_d_in[15:0];
    if (tx_wr_en && !tx_addr && !tx_hold) start_cnt <= 4'd3;
    else if (start_cnt != 0) start_cnt <= start_cnt - 1'b1;
    if (start_cnt == 4'd1) sip_cnt <= 4'd6;
    else if (sip_cnt != 0) sip_cnt <= sip_cnt - 1'b1;
  end

  sl_tx_scheduler #(.N_REQ(4), .ID_W(2), .START_TIMEOUT(8)) dut (
    .clk(clk), .rst(rst), .req(req), .req_data(req_data), .req_bq(req_bq),
    .req_fq(req_fq), .ack(ack), .err(err), .busy(busy), .grant_id(grant_id),
    .tx_d_in(tx_d_in), .tx_addr(tx_addr), .tx_wr_en(tx_wr_en), .tx_d_out(tx_d_out)
  );

  always #31 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h required=%0h", nm, got, exp);
    end
  endtask

  // Monitor: every strobe/response must match the head of its queue.
  always @(negedge clk) begin
    if (!rst) begin
      if (tx_wr_en) begin
        if (exp_wr.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_wr got addr=%0d data=%0h required none", tx_addr, tx_d_in);
        end else begin
          ew = exp_wr.pop_front();
          chk("tx_write", {31'h0, tx_addr, tx_d_in}, {31'h0, ew});
        end
      end
      if ((ack | err) != 0) begin
        if (exp_resp.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_resp got ack=%b err=%b required none", ack, err);
        end else begin
          er = exp_resp.pop_front();
          chk("resp", {56'h0, ack, err}, {56'h0, er});
        end
      end
    end
  end

  task automatic set_req(input int i, input logic [31:0] d, input logic [5:0] b, input logic [2:0] f);
    req_data[i*32 +: 32] = d;
    req_bq[i*6 +: 6]     = b;
    req_fq[i*3 +: 3]     = f;
  endtask

  // Raise mask, drop each bit on its ack/err; check first grant, data-write
  // latency and data-write-to-first-response gap (-1 skips a check).
  task automatic run(input string nm, input logic [N-1:0] mask, input int exp_gid,
                     input int exp_lat, input int exp_gap);
    logic [N-1:0] pend;
    int n, n_wr;
    bit seen_busy, seen_wr, seen_resp;
    pend = mask; n = 0; n_wr = 0;
    seen_busy = 0; seen_wr = 0; seen_resp = 0;
    req = req | mask;
    while (pend != 0 && n < 300) begin
      @(negedge clk);
      n++;
      if (busy && !seen_busy) begin
        seen_busy = 1;
        chk({nm, "_grant_id"}, 64'(grant_id), 64'(exp_gid));
      end
      if (tx_wr_en && !tx_addr && !seen_wr) begin
        seen_wr = 1; n_wr = n;
        if (exp_lat >= 0) chk({nm, "_latency"}, 64'(n), 64'(exp_lat));
      end
      if ((ack | err) != 0 && !seen_resp) begin
        seen_resp = 1;
        if (exp_gap >= 0) chk({nm, "_resp_gap"}, 64'(n - n_wr), 64'(exp_gap));
      end
      pend = pend & ~(ack | err);
      req  = req & ~(ack | err);
    end
    if (pend != 0) begin
      checks++; failures++;
      $display("FAIL %s_timeout got pending=%b required 0", nm, pend);
    end
    @(negedge clk);
    chk({nm, "_busy_after"}, 64'(busy), 64'(0));
  endtask

  initial begin
    int n;
    repeat (3) @(negedge clk);
    chk("reset_outs", {27'h0, ack, err, busy, grant_id, tx_wr_en, tx_addr},
                      {27'h0, 4'h0, 4'h0, 1'b0, 2'd0, 1'b0, 1'b1});
    chk("reset_d_in", 64'(tx_d_in), 64'(0));
    rst = 1'b0;
    @(negedge clk);

    // 1: matching config, no config write
    set_req(0, 32'hA5, 6'd8, 3'd2);
    exp_wr.push_back({1'b0, 32'hA5});
    exp_resp.push_back({4'b0001, 4'b0000});
    run("t1", 4'b0001, 0, 2, 11);

    // 2: two at once from ptr=1 -> 1 then 2
    set_req(1, 32'h1111_0001, 6'd8, 3'd2);
    set_req(2, 32'h2222_0002, 6'd8, 3'd2);
    exp_wr.push_back({1'b0, 32'h1111_0001});
    exp_wr.push_back({1'b0, 32'h2222_0002});
    exp_resp.push_back({4'b0010, 4'b0000});
    exp_resp.push_back({4'b0100, 4'b0000});
    run("t2", 4'b0110, 1, 2, 11);

    // 3: ptr=3 -> req3 (cfg 0x0040) then req0 (cfg back to 0x0210)
    set_req(3, 32'h3333_0003, 6'd32, 3'd0);
    set_req(0, 32'h0000_00C0, 6'd8, 3'd2);
    exp_wr.push_back({1'b1, 32'h0000_0040});
    exp_wr.push_back({1'b0, 32'h3333_0003});
    exp_wr.push_back({1'b1, 32'h0000_0210});
    exp_wr.push_back({1'b0, 32'h0000_00C0});
    exp_resp.push_back({4'b1000, 4'b0000});
    exp_resp.push_back({4'b0001, 4'b0000});
    run("t3", 4'b1001, 3, 4, 11);

    // 4: rejected configs, then boundary fq=4 accepted
    set_req(0, 32'hBAD0, 6'd7, 3'd2);
    exp_resp.push_back({4'b0000, 4'b0001});
    run("t4_bq7", 4'b0001, 0, -1, -1);
    set_req(0, 32'hBAD1, 6'd8, 3'd5);
    exp_resp.push_back({4'b0000, 4'b0001});
    run("t4_fq5", 4'b0001, 0, -1, -1);
    set_req(0, 32'hBAD2, 6'd34, 3'd2);
    exp_resp.push_back({4'b0000, 4'b0001});
    run("t4_bq34", 4'b0001, 0, -1, -1);
    set_req(0, 32'h0000_0F04, 6'd8, 3'd4);
    exp_wr.push_back({1'b1, 32'h0000_0410});
    exp_wr.push_back({1'b0, 32'h0000_0F04});
    exp_resp.push_back({4'b0001, 4'b0000});
    run("t4_fq4", 4'b0001, 0, 4, 11);

    // 5: transmitter never starts -> timeout error
    tx_hold = 1'b1;
    set_req(1, 32'h7170_0005, 6'd8, 3'd4);
    exp_wr.push_back({1'b0, 32'h7170_0005});
    exp_resp.push_back({4'b0000, 4'b0010});
    run("t5", 4'b0010, 1, 2, 9);
    tx_hold = 1'b0;

    // SIP held high by someone else: no grant until it clears
    sip_force = 1'b1;
    set_req(2, 32'h5717_0002, 6'd8, 3'd4);
    req[2] = 1'b1;
    repeat (6) @(negedge clk);
    chk("stuck_sip_busy", 64'(busy), 64'(0));
    sip_force = 1'b0;
    exp_wr.push_back({1'b0, 32'h5717_0002});
    exp_resp.push_back({4'b0100, 4'b0000});
    run("stuck", 4'b0100, 2, -1, 11);

    // 6: reset during WAIT_DONE
    set_req(0, 32'h6666_0006, 6'd16, 3'd2);
    exp_wr.push_back({1'b1, 32'h0000_0220});
    exp_wr.push_back({1'b0, 32'h6666_0006});
    req[0] = 1'b1;
    n = 0;
    while (!sip_m && n < 60) begin @(negedge clk); n++; end
    chk("t6_sip_seen", 64'(sip_m), 64'(1));
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("t6_reset_outs", {27'h0, ack, err, busy, grant_id, tx_wr_en, tx_addr},
                         {27'h0, 4'h0, 4'h0, 1'b0, 2'd0, 1'b0, 1'b1});
    chk("t6_reset_d_in", 64'(tx_d_in), 64'(0));
    rst = 1'b0;
    req = '0;
    n = 0;
    while (sip_m && n < 60) begin @(negedge clk); n++; end
    // ptr back at 0 and shadow back at 0x0210: req0 first, no config writes
    set_req(0, 32'h0000_0A00, 6'd8, 3'd2);
    set_req(3, 32'h0000_0A03, 6'd8, 3'd2);
    exp_wr.push_back({1'b0, 32'h0000_0A00});
    exp_wr.push_back({1'b0, 32'h0000_0A03});
    exp_resp.push_back({4'b0001, 4'b0000});
    exp_resp.push_back({4'b1000, 4'b0000});
    run("t6_post", 4'b1001, 0, 2, 11);

    repeat (3) @(negedge clk);
    chk("wr_queue_drained", 64'(exp_wr.size()), 64'(0));
    chk("resp_queue_drained", 64'(exp_resp.size()), 64'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout got running required finished");
    $fatal(1);
  end

endmodule
